// File: rtl/cog_mode_scheduler.sv
// Exploit/explore mode scheduler: dwell hysteresis, settle window on switches, explore timeout; mode shows 1 cycle after a decision.
// No backpressure; define COG_SCHED_STATS_EN to build the wrapping switch_cnt stable-entry counter (otherwise tied to 0).
module cog_mode_scheduler #(
  parameter logic [3:0] MIN_DWELL   = 4'd2,
  parameter logic [3:0] SETTLE_CYC  = 4'd3,
  parameter logic [7:0] EXPLORE_MAX = 8'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       theta_tick,
  input  logic       cyc_start,
  input  logic       exploit_mode,
  input  logic       explore_mode,
  input  logic       err_explore,
  input  logic [1:0] confidence_level,
  output logic [1:0] mode,
  output logic       learn_en,
  output logic [1:0] lr_shift,
  output logic       w_max_en,
  output logic       gate_boost,
  output logic       switch_pulse,
  output logic       ep_reset,
  output logic [7:0] switch_cnt
);

  typedef enum logic [1:0] {
    S_NEUTRAL = 2'd0,
    S_EXPLOIT = 2'd1,
    S_EXPLORE = 2'd2,
    S_SETTLE  = 2'd3
  } state_t;

  // A SETTLE_CYC of 0 still spends one gamma start in SETTLE.
  localparam logic [3:0] SETTLE_MAX = (SETTLE_CYC == 4'd0) ? 4'd1 : SETTLE_CYC;

  state_t     state;
  logic       target;   // 1 = EXPLORE, 0 = EXPLOIT
  logic [3:0] dwell_cnt;
  logic [3:0] settle_cnt;
  logic [7:0] explore_ticks;

  logic       exp_req;
  logic       expl_req;
  logic       dwell_ok;
  logic [3:0] dwell_inc;
  logic [3:0] settle_inc;
  logic [7:0] ticks_inc;

  assign exp_req    = explore_mode | err_explore;
  assign expl_req   = exploit_mode & ~exp_req;
  assign dwell_ok   = (dwell_cnt >= MIN_DWELL);
  assign dwell_inc  = (dwell_cnt < MIN_DWELL) ? dwell_cnt + 4'd1 : dwell_cnt;
  assign settle_inc = settle_cnt + 4'd1;
  assign ticks_inc  = explore_ticks + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_NEUTRAL;
      target        <= 1'b1;
      dwell_cnt     <= 4'd0;
      settle_cnt    <= 4'd0;
      explore_ticks <= 8'd0;
      switch_pulse  <= 1'b0;
      ep_reset      <= 1'b0;
    end else begin
      switch_pulse <= 1'b0;
      ep_reset     <= 1'b0;
      case (state)
        S_NEUTRAL: begin
          if (theta_tick) begin
            if (exp_req | expl_req) begin
              state      <= S_SETTLE;
              target     <= exp_req;
              settle_cnt <= 4'd0;
              dwell_cnt  <= 4'd0;
            end else begin
              dwell_cnt <= dwell_inc;
            end
          end
        end
        S_EXPLOIT: begin
          // err_explore bypasses both dwell and theta alignment.
          if (err_explore || (theta_tick && dwell_ok && exp_req)) begin
            state      <= S_SETTLE;
            target     <= 1'b1;
            settle_cnt <= 4'd0;
            dwell_cnt  <= 4'd0;
          end else if (theta_tick && dwell_ok && !expl_req) begin
            state        <= S_NEUTRAL;
            dwell_cnt    <= 4'd0;
            switch_pulse <= 1'b1;
          end else if (theta_tick) begin
            dwell_cnt <= dwell_inc;
          end
        end
        S_EXPLORE: begin
          if (theta_tick && dwell_ok && expl_req) begin
            state         <= S_SETTLE;
            target        <= 1'b0;
            settle_cnt    <= 4'd0;
            dwell_cnt     <= 4'd0;
            explore_ticks <= 8'd0;
          end else if (theta_tick && dwell_ok && !exp_req) begin
            state         <= S_NEUTRAL;
            dwell_cnt     <= 4'd0;
            explore_ticks <= 8'd0;
            switch_pulse  <= 1'b1;
          end else if (theta_tick) begin
            dwell_cnt <= dwell_inc;
            // An exit on the same tick takes precedence over the timeout.
            if ((EXPLORE_MAX != 8'd0) && (ticks_inc == EXPLORE_MAX)) begin
              ep_reset      <= 1'b1;
              explore_ticks <= 8'd0;
            end else begin
              explore_ticks <= ticks_inc;
            end
          end
        end
        S_SETTLE: begin
          if (err_explore && !target) begin
            target     <= 1'b1;
            settle_cnt <= 4'd0;
          end else if (cyc_start) begin
            if (settle_inc >= SETTLE_MAX) begin
              state        <= target ? S_EXPLORE : S_EXPLOIT;
              settle_cnt   <= 4'd0;
              dwell_cnt    <= 4'd0;
              switch_pulse <= 1'b1;
            end else begin
              settle_cnt <= settle_inc;
            end
          end
        end
        default: state <= S_NEUTRAL;
      endcase
    end
  end

  assign mode       = state;
  assign learn_en   = (state != S_SETTLE);
  assign w_max_en   = (state == S_EXPLOIT) && (confidence_level == 2'd3);
  assign gate_boost = (state == S_EXPLORE) || ((state == S_SETTLE) && target);

  always_comb begin
    lr_shift = 2'd1;
    case (state)
      S_EXPLOIT: lr_shift = (confidence_level == 2'd3) ? 2'd0 : 2'd1;
      S_NEUTRAL: lr_shift = 2'd1;
      S_EXPLORE: lr_shift = 2'd2;
      S_SETTLE:  lr_shift = 2'd3;
      default:   lr_shift = 2'd1;
    endcase
  end

`ifdef COG_SCHED_STATS_EN
  logic [7:0] switch_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      switch_cnt_q <= 8'd0;
    end else if (switch_pulse) begin
      switch_cnt_q <= switch_cnt_q + 8'd1;
    end
  end

  assign switch_cnt = switch_cnt_q;
`else
  assign switch_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_cog_mode_scheduler.sv
// Directed bench for cog_mode_scheduler at default parameters (dwell 2, settle 3, explore timeout 16).
module tb_cog_mode_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       theta_tick = 1'b0;
  logic       cyc_start = 1'b0;
  logic       exploit_mode = 1'b0;
  logic       explore_mode = 1'b0;
  logic       err_explore = 1'b0;
  logic [1:0] confidence_level = 2'd3;
  logic [1:0] mode;
  logic       learn_en;
  logic [1:0] lr_shift;
  logic       w_max_en;
  logic       gate_boost;
  logic       switch_pulse;
  logic       ep_reset;
  logic [7:0] switch_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cog_mode_scheduler #(.MIN_DWELL(4'd2), .SETTLE_CYC(4'd3), .EXPLORE_MAX(8'd16)) dut (
    .clk(clk), .rst_n(rst_n), .theta_tick(theta_tick), .cyc_start(cyc_start),
    .exploit_mode(exploit_mode), .explore_mode(explore_mode), .err_explore(err_explore),
    .confidence_level(confidence_level), .mode(mode), .learn_en(learn_en),
    .lr_shift(lr_shift), .w_max_en(w_max_en), .gate_boost(gate_boost),
    .switch_pulse(switch_pulse), .ep_reset(ep_reset), .switch_cnt(switch_cnt)
  );

  // One clock with the given strobes; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic th, input logic cs);
    theta_tick = th;
    cyc_start  = cs;
    @(posedge clk);
    #1;
    theta_tick = 1'b0;
    cyc_start  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d want=0", mode); end
    total++; if (learn_en !== 1'b1) begin bad++; $display("FAIL reset_learn_en got=%b want=1", learn_en); end
    total++; if (lr_shift !== 2'd1) begin bad++; $display("FAIL reset_lr_shift got=%0d want=1", lr_shift); end
    total++; if (w_max_en !== 1'b0) begin bad++; $display("FAIL reset_w_max_en got=%b want=0", w_max_en); end
    total++; if (gate_boost !== 1'b0) begin bad++; $display("FAIL reset_gate_boost got=%b want=0", gate_boost); end
    total++; if (switch_pulse !== 1'b0) begin bad++; $display("FAIL reset_switch_pulse got=%b want=0", switch_pulse); end
    total++; if (ep_reset !== 1'b0) begin bad++; $display("FAIL reset_ep_reset got=%b want=0", ep_reset); end
    total++; if (switch_cnt !== 8'd0) begin bad++; $display("FAIL reset_switch_cnt got=%0d want=0", switch_cnt); end
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_exploit_entry();
    exploit_mode = 1'b1;
    confidence_level = 2'd3;
    cyc(1'b1, 1'b1);  // gamma start in the entry cycle must not count
    total++; if (mode !== 2'd3) begin bad++; $display("FAIL entry_settle_mode got=%0d want=3", mode); end
    total++; if (learn_en !== 1'b0) begin bad++; $display("FAIL entry_settle_learn got=%b want=0", learn_en); end
    total++; if (lr_shift !== 2'd3) begin bad++; $display("FAIL entry_settle_lr got=%0d want=3", lr_shift); end
    total++; if (gate_boost !== 1'b0) begin bad++; $display("FAIL entry_settle_boost got=%b want=0", gate_boost); end
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    total++; if (mode !== 2'd3) begin bad++; $display("FAIL entry_settle2_mode got=%0d want=3", mode); end
    cyc(1'b0, 1'b1);
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL entry_exploit_mode got=%0d want=1", mode); end
    total++; if (switch_pulse !== 1'b1) begin bad++; $display("FAIL entry_pulse got=%b want=1", switch_pulse); end
    total++; if (lr_shift !== 2'd0) begin bad++; $display("FAIL entry_lr_conf3 got=%0d want=0", lr_shift); end
    total++; if (w_max_en !== 1'b1) begin bad++; $display("FAIL entry_wmax_conf3 got=%b want=1", w_max_en); end
    cyc(1'b0, 1'b0);
    total++; if (switch_pulse !== 1'b0) begin bad++; $display("FAIL entry_pulse_width got=%b want=0", switch_pulse); end
    confidence_level = 2'd2;
    #1;
    total++; if (w_max_en !== 1'b0) begin bad++; $display("FAIL entry_wmax_conf2 got=%b want=0", w_max_en); end
    total++; if (lr_shift !== 2'd1) begin bad++; $display("FAIL entry_lr_conf2 got=%0d want=1", lr_shift); end
    confidence_level = 2'd3;
  endtask

  task automatic test_dwell();
    exploit_mode = 1'b0;
    explore_mode = 1'b1;
    cyc(1'b1, 1'b0);
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL dwell_tick1 got=%0d want=1", mode); end
    cyc(1'b1, 1'b0);
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL dwell_tick2 got=%0d want=1", mode); end
    cyc(1'b1, 1'b0);
    total++; if (mode !== 2'd3) begin bad++; $display("FAIL dwell_tick3 got=%0d want=3", mode); end
    total++; if (gate_boost !== 1'b1) begin bad++; $display("FAIL dwell_boost got=%b want=1", gate_boost); end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL dwell_explore_mode got=%0d want=2", mode); end
    total++; if (switch_pulse !== 1'b1) begin bad++; $display("FAIL dwell_explore_pulse got=%b want=1", switch_pulse); end
    total++; if (lr_shift !== 2'd2) begin bad++; $display("FAIL dwell_explore_lr got=%0d want=2", lr_shift); end
  endtask

  task automatic test_retarget();
    explore_mode = 1'b0;
    exploit_mode = 1'b1;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL retarget_dwell got=%0d want=2", mode); end
    cyc(1'b1, 1'b0);
    total++; if (mode !== 2'd3) begin bad++; $display("FAIL retarget_settle got=%0d want=3", mode); end
    total++; if (gate_boost !== 1'b0) begin bad++; $display("FAIL retarget_boost_pre got=%b want=0", gate_boost); end
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    err_explore = 1'b1;
    cyc(1'b0, 1'b1);  // retarget cycle: this gamma start is not counted
    err_explore = 1'b0;
    total++; if (mode !== 2'd3) begin bad++; $display("FAIL retarget_mode got=%0d want=3", mode); end
    total++; if (gate_boost !== 1'b1) begin bad++; $display("FAIL retarget_boost got=%b want=1", gate_boost); end
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    total++; if (mode !== 2'd3) begin bad++; $display("FAIL retarget_recount got=%0d want=3", mode); end
    cyc(1'b0, 1'b1);
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL retarget_final got=%0d want=2", mode); end
  endtask

  task automatic test_err_bypass();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL bypass_in_exploit got=%0d want=1", mode); end
    err_explore = 1'b1;
    cyc(1'b0, 1'b0);
    err_explore = 1'b0;
    total++; if (mode !== 2'd3) begin bad++; $display("FAIL bypass_settle got=%0d want=3", mode); end
    total++; if (gate_boost !== 1'b1) begin bad++; $display("FAIL bypass_boost got=%b want=1", gate_boost); end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL bypass_final got=%0d want=2", mode); end
  endtask

  task automatic test_timeout();
    logic want;
    exploit_mode = 1'b0;
    explore_mode = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      if (i == 17) begin
        explore_mode = 1'b0;
        err_explore  = 1'b1;
      end
      cyc(1'b1, 1'b0);
      want = (i == 16) || (i == 32);
      total++; if (ep_reset !== want) begin bad++; $display("FAIL timeout_ep tick=%0d got=%b want=%b", i, ep_reset, want); end
      total++; if (mode !== 2'd2) begin bad++; $display("FAIL timeout_mode tick=%0d got=%0d want=2", i, mode); end
    end
    err_explore  = 1'b0;
    explore_mode = 1'b1;
    cyc(1'b0, 1'b0);
    total++; if (ep_reset !== 1'b0) begin bad++; $display("FAIL timeout_pulse_width got=%b want=0", ep_reset); end
  endtask

  task automatic test_exit_beats_timeout();
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0);
    explore_mode = 1'b0;
    cyc(1'b1, 1'b0);
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL exitwin_mode got=%0d want=0", mode); end
    total++; if (ep_reset !== 1'b0) begin bad++; $display("FAIL exitwin_ep got=%b want=0", ep_reset); end
    total++; if (switch_pulse !== 1'b1) begin bad++; $display("FAIL exitwin_pulse got=%b want=1", switch_pulse); end
  endtask

  task automatic test_reset_mid_settle();
    exploit_mode = 1'b1;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    rst_n = 1'b0;
    cyc(1'b0, 1'b1);
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL midreset_mode got=%0d want=0", mode); end
    total++; if (learn_en !== 1'b1) begin bad++; $display("FAIL midreset_learn got=%b want=1", learn_en); end
    total++; if (gate_boost !== 1'b0) begin bad++; $display("FAIL midreset_boost got=%b want=0", gate_boost); end
    rst_n = 1'b1;
    exploit_mode = 1'b0;
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_stats();
    logic [7:0] want_cnt;
`ifdef COG_SCHED_STATS_EN
    want_cnt = 8'd44;
`else
    want_cnt = 8'd0;
`endif
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int r = 0; r < 150; r++) begin
      exploit_mode = 1'b1;
      cyc(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
      total++; if (mode !== 2'd1) begin bad++; $display("FAIL stats_exploit round=%0d got=%0d want=1", r, mode); end
      exploit_mode = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
      total++; if (mode !== 2'd0) begin bad++; $display("FAIL stats_neutral round=%0d got=%0d want=0", r, mode); end
    end
    cyc(1'b0, 1'b0);
    total++; if (switch_cnt !== want_cnt) begin bad++; $display("FAIL stats_count got=%0d want=%0d", switch_cnt, want_cnt); end
  endtask

  initial begin
    #2;
    test_reset();
    test_exploit_entry();
    test_dwell();
    test_retarget();
    test_err_bypass();
    test_timeout();
    test_exit_beats_timeout();
    test_reset_mid_settle();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cog_mode_scheduler.md
# cog_mode_scheduler

Sequences the learning datapath from the metacognition monitor's `exploit_mode`, `explore_mode`, `err_explore` and `confidence_level` outputs. Applies dwell-time hysteresis, a learning-freeze settle window on every exploit/explore switch, and an explore timeout that requests an episode reset. Drives learning enable, learning-rate shift, W_MAX permission and context-gate boost for the STDP/context blocks downstream.

## Interface
Parameters:
- `MIN_DWELL` [3:0], default 4'd2: theta ticks a stable state must be held before a normal switch away from it; 0 means no dwell requirement.
- `SETTLE_CYC` [3:0], default 4'd3: `cyc_start` pulses spent in SETTLE; 0 is treated as 1.
- `EXPLORE_MAX` [7:0], default 8'd16: theta ticks in EXPLORE before `ep_reset` fires; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `theta_tick` in 1: theta-cycle strobe, one cycle wide.
- `cyc_start` in 1: gamma-cycle start strobe, one cycle wide.
- `exploit_mode` in 1: exploit request from the metacognition monitor.
- `explore_mode` in 1: explore request from the monitor.
- `err_explore` in 1: error-forced explore, high-priority bypass.
- `confidence_level` in 2: confidence level from the monitor.
- `mode` out 2: current state: 0 NEUTRAL, 1 EXPLOIT, 2 EXPLORE, 3 SETTLE.
- `learn_en` out 1: plasticity enable.
- `lr_shift` out 2: learning-rate right-shift; 0 is fastest.
- `w_max_en` out 1: permits weights to reach W_MAX.
- `gate_boost` out 1: strengthens `context_gate` toward rel.
- `switch_pulse` out 1: one-cycle pulse when a stable state is entered.
- `ep_reset` out 1: one-cycle episode-reset request.
- `switch_cnt` out 8: count of stable-state entries. See Configuration.

## Operation
Registers: `state`, `target` (1 bit: EXPLOIT or EXPLORE), `dwell_cnt[3:0]` (saturates at MIN_DWELL), `settle_cnt[3:0]`, `explore_ticks[7:0]`.

Request decode. When both requests are high, explore wins. `exp_req = explore_mode | err_explore`. `expl_req = exploit_mode & ~exp_req`. `dwell_ok = (dwell_cnt >= MIN_DWELL)`.

Transitions:
- NEUTRAL, on theta_tick:
  - `exp_req` → SETTLE with target EXPLORE.
  - else `expl_req` → SETTLE with target EXPLOIT.
- EXPLOIT:
  - `err_explore` on any cycle → SETTLE with target EXPLORE. Ignores dwell and theta.
  - else on theta_tick with `dwell_ok`: `exp_req` → SETTLE with target EXPLORE; neither request → NEUTRAL directly, no settle.
- EXPLORE, on theta_tick with `dwell_ok`:
  - `expl_req` → SETTLE with target EXPLOIT.
  - neither request → NEUTRAL.
  - `err_explore` never lets EXPLORE exit.
- SETTLE:
  - Each `cyc_start` increments `settle_cnt`.
  - On the cyc_start that reaches `max(SETTLE_CYC,1)`, enter `target`.
  - `err_explore` while target is EXPLOIT → retarget to EXPLORE and clear `settle_cnt`. That same cycle's cyc_start is not counted.
  - A cyc_start in the cycle SETTLE is entered is not counted.

Counters:
- `dwell_cnt` clears on every state change and increments on theta_tick in NEUTRAL, EXPLOIT and EXPLORE.
- `explore_ticks` increments on theta_tick in EXPLORE.
  - When it reaches EXPLORE_MAX (if nonzero), it pulses `ep_reset` and clears. State stays EXPLORE.
  - It clears on leaving EXPLORE.
  - If an exit and the timeout occur on the same tick, the exit wins and there is no `ep_reset`.

Outputs are a Moore decode of `state`:
- `learn_en`: 0 in SETTLE, 1 otherwise.
- `lr_shift`:
  - EXPLOIT: 0 if `confidence_level==3`, else 1.
  - NEUTRAL: 1.
  - EXPLORE: 2.
  - SETTLE: 3.
- `w_max_en = (state==EXPLOIT) & (confidence_level==3)`. This is combinational on `confidence_level`.
- `gate_boost = (state==EXPLORE) | (state==SETTLE & target==EXPLORE)`.
- `switch_pulse` is registered and is high for the cycle after entry into NEUTRAL, EXPLOIT or EXPLORE.

## Timing
- Reset values:
  - state NEUTRAL; `mode`=0, `learn_en`=1, `lr_shift`=1, `w_max_en`=0, `gate_boost`=0, `switch_pulse`=0, `ep_reset`=0, `switch_cnt`=0.
  - All counters 0; `target` is EXPLORE.
- A reset asserted mid-SETTLE or mid-count returns to the reset values on the next edge. There is no pending retarget.
- A request sampled on a theta_tick edge shows on `mode` the following cycle.
- Minimum exploit↔explore switch latency is 1 + SETTLE_CYC gamma starts.
- `ep_reset` is asserted in the cycle after the timing-out theta_tick.
- theta_tick and cyc_start in the same cycle are both processed. The theta decision is evaluated on the pre-edge state.

## Configuration
- `COG_SCHED_STATS_EN` defined: `switch_cnt` increments on each `switch_pulse` and wraps at 255 back to 0.
- Not defined: `switch_cnt` is tied to 8'd0 and its counter is not synthesized. All other behaviour is identical.

## Test plan
- Reset, then `exploit_mode`=1 with theta_tick → `mode`=3 for 3 cyc_starts with `learn_en`=0, then `mode`=1, `switch_pulse`=1 for one cycle, `lr_shift`=0 and `w_max_en`=1 at conf=3.
- In EXPLOIT with dwell_cnt=0, `explore_mode`=1 with theta_tick → stays EXPLOIT. After 2 ticks, the next tick → SETTLE, `gate_boost`=1.
- In EXPLOIT, pulse `err_explore` between theta ticks → `mode`=3 next cycle with target EXPLORE. Final `mode`=2.
- During SETTLE toward EXPLOIT with settle_cnt=2, assert `err_explore` → settle_cnt clears, 3 further cyc_starts are needed, final `mode`=2.
- Hold `explore_mode`=1 in EXPLORE for 16 theta ticks → one `ep_reset` pulse, `mode` stays 2. 32 ticks → second pulse.
- With `COG_SCHED_STATS_EN` defined, run 300 stable-state entries → `switch_cnt`=44. Without the macro it reads 0.
